// File: rtl/intr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// intr_ctrl_pkg : shared encodings for the interrupt controller
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [1:0] c_REG_MASK    = 2'd0;
    localparam logic [1:0] c_REG_PENDING = 2'd1;
    localparam logic [1:0] c_REG_STATUS  = 2'd2;

    localparam logic [1:0] c_SRC_FACCEL  = 2'd3;
    localparam logic [1:0] c_SRC_FPM     = 2'd2;

endpackage

`default_nettype wire

// File: rtl/intr_ctrl_prio_enc.sv
// ----------------------------------------------------------------------------
// prio_enc : index of the highest set bit plus a valid flag
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan so the last hit, the highest index, wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ----------------------------------------------------------------------------
// intr_ctrl : sync/edge-detect of SoC done flags, masked priority, irq/ack/eret
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] ex_int,
    input  logic             we,
    input  logic [1:0]       A,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             irq,
    output logic [1:0]       irq_id,
    output logic [31:0]      isr_addr,
    input  logic             irq_ack,
    input  logic             eret
);

    logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] w_edge, w_w1c, w_ack_clr, w_eligible;
    logic [1:0]       w_win_id;
    logic             w_win_vld;
    logic             w_unused_wd;
    state_t           state_q;
    logic             irq_q;
    logic [1:0]       irq_id_q;

    assign w_unused_wd = ^wd[31:N_SRC];

    assign w_edge     = sync2_q & ~sync3_q;
    assign w_w1c      = (we && A == c_REG_PENDING) ? wd[N_SRC-1:0] : '0;
    assign w_ack_clr  = (state_q == REQ && irq_ack)
                        ? ({{(N_SRC-1){1'b0}}, 1'b1} << irq_id_q) : '0;
    assign w_eligible = pending_q & mask_q;

    // Edge is OR-ed last so a fresh edge beats a same-cycle W1C or ack clear.
    always_comb begin
        pending_d = (pending_q & ~w_w1c & ~w_ack_clr) | w_edge;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            sync1_q   <= ex_int;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
            if (we && A == c_REG_MASK) begin
                mask_q <= wd[N_SRC-1:0];
            end
        end
    end

    prio_enc #(
        .N     (N_SRC),
        .IDX_W (2)
    ) u_prio_enc (
        .vec_i   (w_eligible),
        .idx_o   (w_win_id),
        .valid_o (w_win_vld)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_win_vld) begin
                        state_q  <= REQ;
                        irq_q    <= 1'b1;
                        irq_id_q <= w_win_id;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state_q <= SVC;
                        irq_q   <= 1'b0;
                    end
                end
                SVC: begin
                    if (eret) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq      = irq_q;
    assign irq_id   = irq_id_q;
    assign isr_addr = VEC_BASE + ({30'd0, irq_id_q} << VEC_SHIFT);

    always_comb begin
        rd = '0;
        case (A)
            c_REG_MASK:    rd[N_SRC-1:0] = mask_q;
            c_REG_PENDING: rd[N_SRC-1:0] = pending_q;
            c_REG_STATUS:  rd[4:0]       = {irq_q, state_q, irq_id_q};
            default:       rd            = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller between the SoC peripheral block and the single-cycle MIPS core. It synchronises and edge-detects the 4-bit `ex_int` done flags (faccel, FPM, two spare) into sticky pending bits. It masks and prioritises them, then runs an irq/ack/eret handshake with the core, supplying a source id and ISR vector address. A small memory-mapped register window, written through the address decoder's spare enable, gives software access to the mask and pending registers.

## Interface
Parameters:
- N_SRC, 4, number of interrupt sources; bit N_SRC-1 is highest priority
- VEC_BASE, 32'h0000_0100, ISR address of source 0
- VEC_SHIFT, 4, log2 of byte stride between vectors

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- ex_int  in  N_SRC  interrupt flags from SoC (level, possibly launched from non-Clk flops)
- we  in  1  register write enable from decoder
- A  in  2  register select (addr_dm[3:2])
- wd  in  32  write data
- rd  out  32  read data, combinational from A
- irq  out  1  interrupt request to core
- irq_id  out  2  id of requested/in-service source
- isr_addr  out  32  VEC_BASE + (irq_id << VEC_SHIFT)
- irq_ack  in  1  core accepts request (1-cycle pulse)
- eret  in  1  core finished ISR (1-cycle pulse)

## Operation
- Input path: 2-flop synchroniser per bit, then rising-edge detect (sync2 & ~sync3); an edge sets `pending[i]`.
- Registers: A=0 MASK (RW, bits [N_SRC-1:0], 1 = enabled); A=1 PENDING (read; write-1-to-clear); A=2 STATUS (RO: [1:0] irq_id, [3:2] state, [4] irq); A=3 reads 0, writes ignored. Unused read bits are 0.
- `eligible = pending & mask`; priority encoder picks the highest set index.
- FSM states: IDLE=0, REQ=1, SVC=2.
  - IDLE: if eligible≠0, latch winner into irq_id and go to REQ.
  - REQ: irq=1; irq_id is frozen even if a higher source arrives or the mask changes. On irq_ack, clear pending[irq_id] and go to SVC.
  - SVC: irq=0, irq_id held. On eret go to IDLE. No nesting.
  - irq_ack outside REQ and eret outside SVC are ignored.
- Simultaneous events on the same bit:
  - A new edge wins over a W1C clear.
  - A new edge wins over an ack clear; pending stays 1 and the interrupt is re-requested after eret.
- Masked pending bits persist. Unmasking them makes them eligible the next cycle.
- Software W1C of pending[irq_id] while in REQ does not cancel the request; it completes normally.

## Timing
- Reset values: irq=0, irq_id=0, isr_addr=VEC_BASE, MASK=0, PENDING=0, sync flops=0, state=IDLE. rd reflects the reset registers.
- ex_int rise at edge k gives pending=1 after edge k+3 (two sync stages plus edge register).
- Pending eligible in IDLE: state=REQ and irq=1 one cycle later.
- irq_ack sampled at edge n: irq=0 and pending bit cleared after edge n.
- eret at edge n: IDLE after edge n. A further eligible source produces irq=1 after edge n+1 at earliest.
- Register writes take effect at the write edge; rd is combinational with no added latency.
- Reset mid-operation: immediate return to IDLE and all state cleared; lost requests are not restored.

## Structure
- Shared package/header:
  - state encodings IDLE/REQ/SVC
  - register offsets MASK=0, PENDING=1, STATUS=2
  - source ids: FACCEL=3, FPM=2
- Sub-module `prio_enc` (N_SRC-wide one-hot/vector to index plus valid), combinational.
- Synchroniser and edge detect stay inline; no separate module.
- The existing `register` module may be reused for MASK.

## Test plan
- Reset then MASK=4'hC, pulse ex_int[3] → pending=4'h8 after 3 edges, irq=1 next cycle, irq_id=3, isr_addr=32'h130.
- ex_int[3] and ex_int[2] rise together, MASK=4'hF → id 3 served first. After ack and eret, id 2 is requested with isr_addr=32'h120.
- MASK=0, pulse ex_int[2] → pending=4'h4, irq stays 0. Write MASK=4'h4 → irq=1 with id 2 one cycle after it becomes eligible.
- Write PENDING=4'h4 (W1C) on the same cycle a new ex_int[2] edge reaches the pending register → pending[2] stays 1.
- In REQ, raise higher-priority ex_int[3] before ack → irq_id stays 2. After eret, id 3 is requested.
- Assert Rst during SVC → irq=0, state=IDLE, MASK=0, PENDING=0 immediately. Stray eret and irq_ack after reset have no effect.
